if_id_fetch_buffer: RTL and testbench
=====================================

Name: if_id_fetch_buffer

Overview:
- Elastic IF/ID buffer directly downstream of the program counter and instruction memory.
- Captures each fetched {PC+4, instruction} pair and presents it to decode through a valid/ready handshake.
- Lets the PC stall signal (PCoff) be driven from buffer fullness rather than directly from decode.
- Flush discards wrong-path fetches on a branch or jump redirect.

Parameters:
- DEPTH, 2: number of buffered entries; power of two, minimum 2.
- DATA_W, 32: width of the PC and instruction fields.
- PTR_W, 1: log2(DEPTH); must be consistent with DEPTH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  reset, synchronous and active-low (0 = reset, sampled on rising Clk).
- Flush  input  1  discard all buffered entries (branch/jump redirect).
- InValid  input  1  fetch stage holds a valid instruction this cycle.
- PCPlus4In  input  DATA_W  PC+4 of the fetched instruction.
- InstructionIn  input  DATA_W  fetched instruction word.
- InReady  output  1  buffer can accept an entry; PCoff = ~InReady at top level.
- OutValid  output  1  head entry is valid for decode.
- OutReady  input  1  decode consumes the head entry this cycle.
- PCPlus4Out  output  DATA_W  PC+4 of the head entry.
- InstructionOut  output  DATA_W  instruction of the head entry.
- Count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries {PCPlus4, Instruction}, with registered read pointer rd_ptr, write pointer wr_ptr and Count.
- Reset (Reset==0 at a rising edge):
  - rd_ptr=0, wr_ptr=0, Count=0.
  - OutValid=0, InReady=1, PCPlus4Out=0, InstructionOut=0.
  - Storage contents are don't-care; outputs are masked by OutValid.
  - Reset overrides Flush, push and pop in the same cycle.
- Output decode:
  - InReady = (Count != DEPTH).
  - OutValid = (Count != 0).
  - PCPlus4Out and InstructionOut show the entry at rd_ptr when Count != 0, and are forced to 0 when Count == 0. These are combinational from registered state.
  - InReady must not depend combinationally on OutReady (no ready pass-through).
- Push: occurs when InValid & InReady & ~Flush. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: occurs when OutValid & OutReady & ~Flush. rd_ptr increments modulo DEPTH.
- Count update:
  - Count+1 on push only.
  - Count-1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full (Count==DEPTH):
  - InReady=0 and no push occurs, even if OutReady=1 in the same cycle.
  - Space frees on the following cycle.
- Empty (Count==0):
  - OutValid=0 and pop is ignored.
  - An entry pushed this cycle appears at the outputs next cycle. Minimum latency is 1 cycle; there is no bypass.
- Flush (synchronous, active-high):
  - Next cycle: rd_ptr=wr_ptr=0, Count=0.
  - A push or pop in the flush cycle is discarded; the incoming InValid entry is dropped.
  - InReady=1 on the cycle after a flush.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap; ordering is strictly FIFO.
- Data stability: while OutValid=1 and OutReady=0, PCPlus4Out and InstructionOut hold steady.
- Reset mid-operation: all in-flight entries are lost, and the state is identical to power-up reset.

Test Plan:
- Reset and idle:
  - Stimulus: hold Reset=0 for 5 cycles, then release.
  - Required: OutValid=0, InReady=1, Count=0, outputs 0.
- Single pass-through:
  - Stimulus: OutReady=1; push {PCPlus4In=4, InstructionIn=0x20080005} for 1 cycle.
  - Required: next cycle OutValid=1, PCPlus4Out=4, InstructionOut=0x20080005; the cycle after, Count=0.
- Fill and stall:
  - Stimulus: OutReady=0; push PC+4 = 4, 8, 12 on consecutive cycles.
  - Required: 4 and 8 accepted, Count=2, InReady=0; 12 held upstream (PCoff=1).
  - Then OutReady=1: outputs 4, then 8, then 12 in order.
- Simultaneous push/pop while full:
  - Stimulus: Count=2, InValid=1, OutReady=1.
  - Required: pop only, Count=1.
  - Next cycle push and pop together: Count stays 1 and order is preserved across pointer wrap.
- Flush with concurrent push:
  - Stimulus: Count=2, assert Flush with InValid=1 and PCPlus4In=16.
  - Required: next cycle Count=0, OutValid=0, InReady=1, and entry 16 never appears at the outputs.
- Reset mid-stream:
  - Stimulus: Count=1, drive Reset=0 for 1 cycle with InValid=1.
  - Required: next cycle Count=0, OutValid=0, outputs 0.

Source files
------------

// File: rtl/if_id_fetch_buffer.sv
// Elastic IF/ID buffer: DEPTH-entry FIFO of {PC+4, instruction}, 1-cycle fill latency, no bypass.
// Backpressure: InReady drops only when full (PCoff = ~InReady), independent of OutReady; Flush empties it.
module if_id_fetch_buffer #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int PTR_W  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [DATA_W-1:0] PCPlus4In,
  input  logic [DATA_W-1:0] InstructionIn,
  output logic              InReady,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] PCPlus4Out,
  output logic [DATA_W-1:0] InstructionOut,
  output logic [PTR_W:0]    Count
);

  typedef struct packed {
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam logic [PTR_W:0] L_FULL = (PTR_W + 1)'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  entry_t           w_in_entry;
  entry_t           w_head;

  // Ready/valid come from registered occupancy only, so there is no OutReady->InReady path.
  assign w_in_ready  = (r_count != L_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = InValid & w_in_ready & ~Flush;
  assign w_pop       = w_out_valid & OutReady & ~Flush;

  assign w_in_entry.pc_plus4 = PCPlus4In;
  assign w_in_entry.instr    = InstructionIn;
  assign w_head              = w_out_valid ? r_mem[r_rd_ptr] : '0;

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (Flush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
        2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset && w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  assign InReady        = w_in_ready;
  assign OutValid       = w_out_valid;
  assign PCPlus4Out     = w_head.pc_plus4;
  assign InstructionOut = w_head.instr;
  assign Count          = r_count;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Self-checking bench for if_id_fetch_buffer: directed vector table plus randomized traffic against a queue model.
module tb_if_id_fetch_buffer;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int PTR_W  = 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Flush;
  logic              InValid;
  logic [DATA_W-1:0] PCPlus4In;
  logic [DATA_W-1:0] InstructionIn;
  logic              InReady;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] PCPlus4Out;
  logic [DATA_W-1:0] InstructionOut;
  logic [PTR_W:0]    Count;

  if_id_fetch_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid),
    .PCPlus4In(PCPlus4In), .InstructionIn(InstructionIn), .InReady(InReady),
    .OutValid(OutValid), .OutReady(OutReady), .PCPlus4Out(PCPlus4Out),
    .InstructionOut(InstructionOut), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Inputs applied this cycle, and outputs expected in the same cycle (from state left by prior edges).
  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        out_rdy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_cnt;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] model_q[$];
  vec_t        tbl[$];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic flush, input logic in_vld,
                              input logic [31:0] pc, input logic [31:0] ins, input logic out_rdy,
                              input logic e_ir, input logic e_ov, input logic [31:0] e_cnt,
                              input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.in_vld = in_vld; v.pc = pc; v.ins = ins;
    v.out_rdy = out_rdy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt;
    v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    logic [63:0] head;
    bit          pop;
    bit          push;
    Reset = v.rst_n; Flush = v.flush; InValid = v.in_vld;
    PCPlus4In = v.pc; InstructionIn = v.ins; OutReady = v.out_rdy;
    #1;
    head = (model_q.size() != 0) ? model_q[0] : 64'd0;
    chk("sb_in_ready",  32'(InReady),  32'(model_q.size() != DEPTH));
    chk("sb_out_valid", 32'(OutValid), 32'(model_q.size() != 0));
    chk("sb_count",     32'(Count),    32'(model_q.size()));
    chk("sb_pc_out",    PCPlus4Out,     head[63:32]);
    chk("sb_ins_out",   InstructionOut, head[31:0]);
    if (use_tbl) begin
      chk("tbl_in_ready",  32'(InReady),  32'(v.e_ir));
      chk("tbl_out_valid", 32'(OutValid), 32'(v.e_ov));
      chk("tbl_count",     32'(Count),    v.e_cnt);
      chk("tbl_pc_out",    PCPlus4Out,     v.e_pc);
      chk("tbl_ins_out",   InstructionOut, v.e_ins);
    end
    if (!v.rst_n || v.flush) begin
      model_q.delete();
    end else begin
      pop  = (model_q.size() != 0) && v.out_rdy;
      push = v.in_vld && (model_q.size() != DEPTH);
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({v.pc, v.ins});
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vec_t v;
    // Reset and idle: first of five reset cycles applied before the table.
    Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; PCPlus4In = '0; InstructionIn = '0; OutReady = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 1, 32'd100, ins_of(32'd100), 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 0, 0, 0, 0));
    // Single pass-through
    tbl.push_back(mk(1, 0, 1, 32'd4, 32'h2008_0005, 1,                1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 1, 1, 32'd4, 32'h2008_0005));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 0, 0, 0, 0));
    // Fill and stall, then drain in order (12 enters across the wrap)
    tbl.push_back(mk(1, 0, 1, 32'd4,  ins_of(32'd4),  0,              1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'd8,  ins_of(32'd8),  0,              1, 1, 1, 32'd4, ins_of(32'd4)));
    tbl.push_back(mk(1, 0, 1, 32'd12, ins_of(32'd12), 0,              0, 1, 2, 32'd4, ins_of(32'd4)));
    tbl.push_back(mk(1, 0, 1, 32'd12, ins_of(32'd12), 1,              0, 1, 2, 32'd4, ins_of(32'd4)));
    tbl.push_back(mk(1, 0, 1, 32'd12, ins_of(32'd12), 1,              1, 1, 1, 32'd8, ins_of(32'd8)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 1, 1, 32'd12, ins_of(32'd12)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 0, 0, 0, 0));
    // Full with push+pop request: pop only; then steady push+pop across wrap
    tbl.push_back(mk(1, 0, 1, 32'd20, ins_of(32'd20), 0,              1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'd24, ins_of(32'd24), 0,              1, 1, 1, 32'd20, ins_of(32'd20)));
    tbl.push_back(mk(1, 0, 1, 32'd28, ins_of(32'd28), 1,              0, 1, 2, 32'd20, ins_of(32'd20)));
    tbl.push_back(mk(1, 0, 1, 32'd28, ins_of(32'd28), 1,              1, 1, 1, 32'd24, ins_of(32'd24)));
    tbl.push_back(mk(1, 0, 1, 32'd32, ins_of(32'd32), 1,              1, 1, 1, 32'd28, ins_of(32'd28)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,                                1, 1, 1, 32'd32, ins_of(32'd32)));
    tbl.push_back(mk(1, 0, 1, 32'd36, ins_of(32'd36), 0,              1, 1, 1, 32'd32, ins_of(32'd32)));
    // Flush while full with a concurrent push of 16
    tbl.push_back(mk(1, 1, 1, 32'd16, ins_of(32'd16), 1,              0, 1, 2, 32'd32, ins_of(32'd32)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'd40, ins_of(32'd40), 0,              1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,                                1, 1, 1, 32'd40, ins_of(32'd40)));
    // Reset mid-stream with a concurrent push
    tbl.push_back(mk(0, 0, 1, 32'd44, ins_of(32'd44), 1,              1, 1, 1, 32'd40, ins_of(32'd40)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'd48, ins_of(32'd48), 0,              1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 1, 1, 32'd48, ins_of(32'd48)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,                                1, 0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Randomized traffic with occasional flush and reset, checked against the queue model.
    for (int n = 0; n < 400; n++) begin
      v = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 1)), $urandom, $urandom, ($urandom_range(0, 3) != 0),
             0, 0, 0, 0, 0);
      step(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
